reg_file_ctrl: RTL
==================

Name: reg_file_ctrl

Overview:
- Initiator-side controller that drives the system register file's write/read port from a byte command stream received over UART RX.
- Decodes write and read command frames and issues single-cycle WrEn/RdEn strobes.
- Forwards read data to the UART TX parallel interface.
- Sits between the UART RX/TX data paths and the register file.

Parameters:
- DATA_WIDTH, 8, width of RX/TX bytes and of register data.
- ADDR_WIDTH, 4, register address width; the low ADDR_WIDTH bits of the address byte are used.
- WR_CMD, 8'hAA, command byte that opens a write frame.
- RD_CMD, 8'hBB, command byte that opens a read frame.
- TIMEOUT, 8, maximum cycles to wait for RdData_Valid after RdEn.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  single-cycle strobe; RX_P_DATA is valid.
- RdData  in  DATA_WIDTH  read data from the register file.
- RdData_Valid  in  1  read data valid strobe from the register file.
- TX_Busy  in  1  UART TX is serialising; a new byte cannot be accepted.
- WrEn  out  1  register file write strobe.
- RdEn  out  1  register file read strobe.
- Address  out  ADDR_WIDTH  register file address.
- WrData  out  DATA_WIDTH  register file write data.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  single-cycle strobe; TX_P_DATA is valid.
- CMD_ERR  out  1  single-cycle error pulse.

Behaviour:
- All outputs are registered. On reset every output is 0 and the FSM returns to IDLE. Reset asserted mid-frame aborts the frame and no strobe is issued.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT.
- IDLE:
  - RX_D_VLD with WR_CMD -> WR_ADDR.
  - RX_D_VLD with RD_CMD -> RD_ADDR.
  - Any other byte: CMD_ERR pulses high for 1 cycle; stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch Address <= RX_P_DATA[ADDR_WIDTH-1:0]; go to WR_DATA.
- WR_DATA: on RX_D_VLD, WrData <= RX_P_DATA and WrEn = 1 for exactly the next cycle; return to IDLE.
- RD_ADDR: on RX_D_VLD, latch Address; RdEn = 1 for exactly the next cycle; clear the timeout counter; go to RD_WAIT.
- RD_WAIT:
  - On the edge where RdData_Valid = 1, TX_P_DATA <= RdData; go to TX_WAIT.
  - The counter increments every cycle. When it reaches TIMEOUT without RdData_Valid, CMD_ERR pulses for 1 cycle and the FSM returns to IDLE.
- TX_WAIT:
  - On the edge where TX_Busy = 0, TX_D_VLD = 1 for exactly the next cycle; return to IDLE.
  - While TX_Busy = 1, hold TX_P_DATA and wait indefinitely.
- Latency, counted in edges after the last frame byte is sampled (E0):
  - WrEn / RdEn are high in the cycle after E0.
  - With a one-cycle register file and TX idle, TX_D_VLD is high in the cycle after E3.
- WrEn and RdEn are never high in the same cycle.
- Address and WrData hold their values after a strobe until the next frame overwrites them.
- RX_D_VLD in RD_WAIT or TX_WAIT: the byte is dropped silently; no CMD_ERR, no state change.
- A command byte arriving in the WR_ADDR/WR_DATA/RD_ADDR slots is treated as data, not as a new command.
- Address byte upper bits (DATA_WIDTH-1:ADDR_WIDTH) are ignored.
- RdData_Valid outside RD_WAIT is ignored.

Test Plan:
- Reset: RST low mid-WR_DATA -> all outputs 0; after release, bytes AA,05,3C -> WrEn pulse 1 cycle, Address=5, WrData=3C, RdEn stays 0.
- Read: preload reg 2 = 8'h21; bytes BB,02 with TX_Busy=0 -> RdEn 1 cycle with Address=2, then TX_D_VLD 1 cycle with TX_P_DATA=21 in the cycle after E3.
- Back-pressure: TX_Busy held high for 20 cycles during a read of reg 3 (=08) -> TX_D_VLD stays 0; it pulses once, with TX_P_DATA=08, one cycle after TX_Busy falls.
- Bad command: byte 5A in IDLE -> CMD_ERR 1 cycle, no strobes; a following AA,01,FF writes reg 1 = FF.
- Timeout: RdData_Valid tied 0 on a read -> CMD_ERR after TIMEOUT=8 cycles, FSM back in IDLE, TX_D_VLD never asserted.
- Address masking and dropped bytes: bytes AA,F7,11 -> Address=7; a byte 99 injected during TX_WAIT -> no CMD_ERR, and the read still completes with the correct data.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// Register-file initiator driven by a UART byte stream: decodes write/read
// frames, issues single-cycle WrEn/RdEn strobes and forwards read data to TX.
module reg_file_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  TX_Busy,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CMD_ERR
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic          timeout_hit;

    logic wr_en_d, rd_en_d, tx_vld_d, err_d;
    logic addr_ld, wdata_ld, tdata_ld, cnt_clr, cnt_inc;

    // Counter is cleared on the address edge, so the last wait edge sees TIMEOUT-1.
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == WR_CMD)      next_state = WR_ADDR;
                else if (RX_P_DATA == RD_CMD) next_state = RD_ADDR;
            end
            WR_ADDR: if (RX_D_VLD) next_state = WR_DATA;
            WR_DATA: if (RX_D_VLD) next_state = IDLE;
            RD_ADDR: if (RX_D_VLD) next_state = RD_WAIT;
            RD_WAIT: begin
                if (RdData_Valid)     next_state = TX_WAIT;
                else if (timeout_hit) next_state = IDLE;
            end
            TX_WAIT: if (!TX_Busy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        tx_vld_d = 1'b0;
        err_d    = 1'b0;
        addr_ld  = 1'b0;
        wdata_ld = 1'b0;
        tdata_ld = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE:    err_d = RX_D_VLD && (RX_P_DATA != WR_CMD) && (RX_P_DATA != RD_CMD);
            WR_ADDR: addr_ld = RX_D_VLD;
            WR_DATA: begin
                wdata_ld = RX_D_VLD;
                wr_en_d  = RX_D_VLD;
            end
            RD_ADDR: begin
                addr_ld = RX_D_VLD;
                rd_en_d = RX_D_VLD;
                cnt_clr = RX_D_VLD;
            end
            RD_WAIT: begin
                if (RdData_Valid)     tdata_ld = 1'b1;
                else if (timeout_hit) err_d    = 1'b1;
                else                  cnt_inc  = 1'b1;
            end
            TX_WAIT: tx_vld_d = !TX_Busy;
            default: ;
        endcase
    end

    // Strobes are pulses; Address/WrData/TX_P_DATA hold until reloaded.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            cnt       <= '0;
        end else begin
            WrEn     <= wr_en_d;
            RdEn     <= rd_en_d;
            TX_D_VLD <= tx_vld_d;
            CMD_ERR  <= err_d;
            if (addr_ld)  Address   <= RX_P_DATA[ADDR_WIDTH-1:0];
            if (wdata_ld) WrData    <= RX_P_DATA;
            if (tdata_ld) TX_P_DATA <= RdData;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
        end
    end

endmodule
